multi_sprite_show: RTL

Parametrised multi-slot sprite renderer for the VGA pixel stream: the generalised successor to the single projectile overlay. It holds NUM_SLOTS independent sprites (position, type, valid), each drawn from an external sprite ROM port. Sprite updates are double-buffered so they apply only at frame start, and sprites can cycle through FRAMES animation frames. For every pixel request it returns, after a fixed 2-cycle latency, the colour of the highest-priority opaque sprite, or "no hit"; the display mixer composes this over the background.

---
 rtl/multi_sprite_show_if.sv | 41 ++++
 rtl/multi_sprite_show.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_sprite_show_if.sv
// Sprite renderer bus: shadow-table write port, frame controls,
// pixel request/response and the per-slot sprite ROM port.
interface multi_sprite_show_if #(
  parameter int NUM_SLOTS = 4,
  parameter int COORD_W   = 10,
  parameter int ADDR_W    = 9
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                        frame_start;
  logic                        anim_en;
  logic                        wr_en;
  logic [SLOT_W-1:0]           wr_slot;
  logic [COORD_W-1:0]          wr_x;
  logic [COORD_W-1:0]          wr_y;
  logic [2:0]                  wr_type;
  logic                        wr_valid;
  logic                        pix_req;
  logic [COORD_W-1:0]          pix_x;
  logic [COORD_W-1:0]          pix_y;
  logic [NUM_SLOTS*ADDR_W-1:0] rom_addr;
  logic [NUM_SLOTS*24-1:0]     rom_data;
  logic                        pix_ack;
  logic [23:0]                 pixel_out;
  logic                        pixel_hit;
  logic [SLOT_W-1:0]           pixel_slot;

  // Host / display controller side
  modport master (
    output frame_start, anim_en, wr_en, wr_slot, wr_x, wr_y, wr_type, wr_valid,
    output pix_req, pix_x, pix_y, rom_data,
    input  rom_addr, pix_ack, pixel_out, pixel_hit, pixel_slot
  );

  // Renderer side
  modport slave (
    input  frame_start, anim_en, wr_en, wr_slot, wr_x, wr_y, wr_type, wr_valid,
    input  pix_req, pix_x, pix_y, rom_data,
    output rom_addr, pix_ack, pixel_out, pixel_hit, pixel_slot
  );
endinterface

// File: rtl/multi_sprite_show.sv
// Multi-slot sprite renderer. Double-buffered sprite table committed at
// frame start, animation frame counter, per-slot hit test and ROM
// addressing, then a 2-cycle pipeline resolving the winning opaque pixel.
module multi_sprite_show #(
  parameter int NUM_SLOTS = 4,
  parameter int SPRITE_W  = 15,
  parameter int SPRITE_H  = 15,
  parameter int COORD_W   = 10,
  parameter int FRAMES    = 2,
  parameter int ANIM_DIV  = 8,
  parameter int ADDR_W    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_sprite_show_if.slave   bus
);
  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int FRM_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int SPRITE_PIX = SPRITE_W * SPRITE_H;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ANIM_DIV - 1);
  localparam logic [FRM_W-1:0]   FRM_LAST = FRM_W'(FRAMES - 1);
  localparam logic [COORD_W:0]   W_M1     = (COORD_W+1)'(SPRITE_W - 1);
  localparam logic [COORD_W:0]   H_M1     = (COORD_W+1)'(SPRITE_H - 1);
  localparam logic [ADDR_W-1:0]  PIX_A    = ADDR_W'(SPRITE_PIX);
  localparam logic [ADDR_W-1:0]  W_A      = ADDR_W'(SPRITE_W);

  logic [CNT_W-1:0]            frame_cnt_reg;
  logic [FRM_W-1:0]            anim_frame_reg;

  logic [NUM_SLOTS-1:0]        hit_vec;
  logic [NUM_SLOTS*3-1:0]      type_vec;
  logic [NUM_SLOTS*ADDR_W-1:0] rom_addr_vec;

  logic [NUM_SLOTS-1:0]        hit_s1_reg;
  logic [NUM_SLOTS*3-1:0]      type_s1_reg;
  logic                        req_s1_reg;

  logic [NUM_SLOTS-1:0]        opaque_vec;
  logic [NUM_SLOTS*24-1:0]     rgb_vec;

  logic                        win_found;
  logic [SLOT_W-1:0]           win_slot;
  logic [23:0]                 win_rgb;

  logic                        pix_ack_reg;
  logic                        pixel_hit_reg;
  logic [SLOT_W-1:0]           pixel_slot_reg;
  logic [23:0]                 pixel_out_reg;

  // Animation: count enabled frame starts, step the frame on each wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg  <= '0;
      anim_frame_reg <= '0;
    end else if (bus.frame_start && bus.anim_en) begin
      if (frame_cnt_reg == CNT_LAST) begin
        frame_cnt_reg  <= '0;
        anim_frame_reg <= (anim_frame_reg == FRM_LAST) ? '0 : anim_frame_reg + 1'b1;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      localparam logic [SLOT_W-1:0] SLOT_ID = SLOT_W'(gi);

      logic [COORD_W-1:0] sh_x_reg, sh_y_reg, act_x_reg, act_y_reg;
      logic [2:0]         sh_type_reg, act_type_reg;
      logic               sh_valid_reg, act_valid_reg;

      logic [COORD_W:0]   px, py, x_lo, x_hi, y_lo, y_hi, row, col;
      logic               hit;
      logic [ADDR_W-1:0]  addr;

      // Shadow entry accepts host writes at any time
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sh_x_reg     <= '0;
          sh_y_reg     <= '0;
          sh_type_reg  <= '0;
          sh_valid_reg <= 1'b0;
        end else if (bus.wr_en && (bus.wr_slot == SLOT_ID)) begin
          sh_x_reg     <= bus.wr_x;
          sh_y_reg     <= bus.wr_y;
          sh_type_reg  <= bus.wr_type;
          sh_valid_reg <= bus.wr_valid;
        end
      end

      // Active entry snapshots the shadow at frame start; a colliding write
      // is not seen here until the following frame start
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          act_x_reg     <= '0;
          act_y_reg     <= '0;
          act_type_reg  <= '0;
          act_valid_reg <= 1'b0;
        end else if (bus.frame_start) begin
          act_x_reg     <= sh_x_reg;
          act_y_reg     <= sh_y_reg;
          act_type_reg  <= sh_type_reg;
          act_valid_reg <= sh_valid_reg;
        end
      end

      // Hit test in one extra bit so sprites near the edge clip, never wrap
      always_comb begin
        px   = {1'b0, bus.pix_x};
        py   = {1'b0, bus.pix_y};
        x_lo = {1'b0, act_x_reg};
        y_lo = {1'b0, act_y_reg};
        x_hi = x_lo + W_M1;
        y_hi = y_lo + H_M1;
        hit  = act_valid_reg && (px >= x_lo) && (px <= x_hi) && (py >= y_lo) && (py <= y_hi);
        row  = y_hi - py;   // ROM stores the bottom row first
        col  = px - x_lo;
        addr = '0;
        if (hit) begin
          addr = ADDR_W'(anim_frame_reg) * PIX_A + ADDR_W'(row) * W_A + ADDR_W'(col);
        end
      end

      assign hit_vec[gi]                        = hit;
      assign type_vec[gi*3 +: 3]                = act_type_reg;
      assign rom_addr_vec[gi*ADDR_W +: ADDR_W]  = addr;
    end
  endgenerate

  assign bus.rom_addr = rom_addr_vec;

  // Stage 0: hold hit vector, colour planes and request while the ROM reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_s1_reg  <= '0;
      type_s1_reg <= '0;
      req_s1_reg  <= 1'b0;
    end else begin
      hit_s1_reg  <= hit_vec;
      type_s1_reg <= type_vec;
      req_s1_reg  <= bus.pix_req;
    end
  end

  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_dec
      logic [23:0] word;
      logic [4:0]  shamt;
      logic [2:0]  code;
      logic [23:0] rgb;

      // Pick this slot's 3-bit plane and map it to RGB888
      always_comb begin
        word  = bus.rom_data[gi*24 +: 24];
        shamt = 5'd21 - 5'd3 * 5'(type_s1_reg[gi*3 +: 3]);
        code  = 3'(word >> shamt);
        case (code[1:0])
          2'b00:   rgb = 24'h000000;
          2'b01:   rgb = 24'hFF0000;
          2'b10:   rgb = 24'h00FF00;
          default: rgb = 24'hFFFF00;
        endcase
      end

      assign opaque_vec[gi]        = hit_s1_reg[gi] && code[2];
      assign rgb_vec[gi*24 +: 24]  = rgb;
    end
  endgenerate

  // Priority: scan high to low so the lowest opaque slot overrides
  always_comb begin
    win_found = 1'b0;
    win_slot  = '0;
    win_rgb   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (opaque_vec[i]) begin
        win_found = 1'b1;
        win_slot  = SLOT_W'(i);
        win_rgb   = rgb_vec[i*24 +: 24];
      end
    end
  end

  // Stage 1: register the resolved pixel; idle cycles output zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_ack_reg    <= 1'b0;
      pixel_hit_reg  <= 1'b0;
      pixel_slot_reg <= '0;
      pixel_out_reg  <= '0;
    end else begin
      pix_ack_reg    <= req_s1_reg;
      pixel_hit_reg  <= req_s1_reg && win_found;
      pixel_slot_reg <= (req_s1_reg && win_found) ? win_slot : '0;
      pixel_out_reg  <= (req_s1_reg && win_found) ? win_rgb : '0;
    end
  end

  assign bus.pix_ack    = pix_ack_reg;
  assign bus.pixel_hit  = pixel_hit_reg;
  assign bus.pixel_slot = pixel_slot_reg;
  assign bus.pixel_out  = pixel_out_reg;
endmodule
